controller_sequencer: RTL
=========================

CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 SHALL have parameter OP_LDA, default 4'b0000, load accumulator from RAM.
REQ-002 SHALL have parameter OP_ADD, default 4'b0001, A <= A + RAM.
REQ-003 SHALL have parameter OP_SUB, default 4'b0010, A <= A - RAM.
REQ-004 SHALL have parameter OP_OUT, default 4'b1110, output register <= A.
REQ-005 SHALL have parameter OP_HLT, default 4'b1111, stop sequencing.
REQ-006 SHALL have port clk  input  1  system clock; the only clock in the block.
REQ-007 SHALL have port clr  input  1  reset, asynchronous and active-high.
REQ-008 SHALL have port opcode  input  4  instruction register upper nibble.
REQ-009 SHALL have port pc_inc  output  1  program counter increment (Cp).
REQ-010 SHALL have port pc_en  output  1  PC drives w_bus (Ep).
REQ-011 SHALL have port mar_load  output  1  MAR load from w_bus[3:0] (Lm).
REQ-012 SHALL have port ram_en  output  1  RAM drives w_bus (CE).
REQ-013 SHALL have port ir_load  output  1  IR load (Li).
REQ-014 SHALL have port ir_en  output  1  IR operand nibble drives w_bus (Ei).
REQ-015 SHALL have port a_load  output  1  accumulator load (La).
REQ-016 SHALL have port a_en  output  1  accumulator drives w_bus (Ea).
REQ-017 SHALL have port sub  output  1  ALU subtract select (Su).
REQ-018 SHALL have port alu_en  output  1  ALU drives w_bus (Eu).
REQ-019 SHALL have port b_load  output  1  B register load (Lb).
REQ-020 SHALL have port out_load  output  1  output register load (Lo).
REQ-021 SHALL have port t_state  output  6  one-hot ring state, bit0 = T1.
REQ-022 SHALL have port halted  output  1  high while in HALT.

Function
REQ-023 SHALL sequence T1..T6 one-hot, advancing on each falling clk edge, T6 wrapping to T1.
REQ-024 SHALL advance state on the falling edge, so all datapath registers load on the rising edge mid-state.
REQ-025 SHALL decode all control outputs combinationally from the current state and the latched opcode; all active-high.
REQ-026 SHALL capture opcode into an internal opcode_q on the T3->T4 falling edge; opcode changes at any other time SHALL have no effect.
REQ-027 SHALL drive T1: pc_en, mar_load.
REQ-028 SHALL drive T2: pc_inc.
REQ-029 SHALL drive T3: ram_en, ir_load.
REQ-030 SHALL drive LDA: T4 ir_en+mar_load; T5 ram_en+a_load; T6 none.
REQ-031 SHALL drive ADD: T4 ir_en+mar_load; T5 ram_en+b_load; T6 alu_en+a_load, sub=0.
REQ-032 SHALL drive SUB: as ADD, except sub=1 in T6 only.
REQ-033 SHALL drive OUT: T4 a_en+out_load; T5 and T6 none.
REQ-034 SHALL enter HALT on HLT at the T3->T4 edge, holding t_state=000000, halted=1 and all controls 0 until clr.
REQ-035 SHALL treat unlisted opcodes as NOP: T4-T6 assert no control, then the sequence continues at T1.
REQ-036 SHALL never assert more than one of pc_en, ram_en, ir_en, a_en, alu_en in any state.

Reset
REQ-037 SHALL, while clr=1, immediately and independent of clk force t_state=000001, opcode_q=0000, halted=0, outputs = T1 word.
REQ-038 SHALL abort the instruction when clr is asserted mid-instruction (including HALT) with no further control pulses; the first falling edge after clr falls SHALL move to T2.

Verification
REQ-039 SHALL cover: clr pulsed between clk edges during T5 of ADD -> t_state=000001, pc_en=1, mar_load=1, b_load=0, no clk edge needed.
REQ-040 SHALL cover: opcode=0000 over one instruction -> pulses T1 pc_en+mar_load, T2 pc_inc, T3 ram_en+ir_load, T4 ir_en+mar_load, T5 ram_en+a_load, T6 none.
REQ-041 SHALL cover: opcode=0010 -> T5 ram_en+b_load, T6 alu_en+a_load+sub=1; sub=0 in all other states.
REQ-042 SHALL cover: opcode=1110 -> T4 a_en+out_load; opcode set to 0000 during T5 leaves T5/T6 silent.
REQ-043 SHALL cover: opcode=1111 -> halted=1, t_state=000000, all controls 0 for 20 cycles; then clr=1 -> T1, halted=0.
REQ-044 SHALL cover: random opcodes over 1000 cycles -> bus-driver one-hot check (REQ-036) and t_state one-hot or zero, never violated.

Source files
------------

// File: rtl/controller_sequencer.sv
// Six-state ring control sequencer for a SAP-1 style accumulator machine.
// State advances on the falling clock edge; control lines are decoded from state and latched opcode.
module controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_en,
  output logic       mar_load,
  output logic       ram_en,
  output logic       ir_load,
  output logic       ir_en,
  output logic       a_load,
  output logic       a_en,
  output logic       sub,
  output logic       alu_en,
  output logic       b_load,
  output logic       out_load,
  output logic [5:0] t_state,
  output logic       halted
);

  // Encoding doubles as the t_state output: one-hot ring, all-zero while halted.
  typedef enum logic [5:0] {
    StT1   = 6'b000001,
    StT2   = 6'b000010,
    StT3   = 6'b000100,
    StT4   = 6'b001000,
    StT5   = 6'b010000,
    StT6   = 6'b100000,
    StHalt = 6'b000000
  } state_e;

  state_e     state_q;
  logic [3:0] opcode_q;

  // Falling-edge sequencing leaves the rising edge mid-state for datapath loads.
  always_ff @(negedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= StT1;
      opcode_q <= 4'b0000;
    end else begin
      unique case (state_q)
        StT1:    state_q <= StT2;
        StT2:    state_q <= StT3;
        StT3: begin
          opcode_q <= opcode;
          state_q  <= (opcode == OP_HLT) ? StHalt : StT4;
        end
        StT4:    state_q <= StT5;
        StT5:    state_q <= StT6;
        StT6:    state_q <= StT1;
        StHalt:  state_q <= StHalt;
        default: state_q <= StT1;
      endcase
    end
  end

  logic is_lda, is_add, is_sub, is_out;

  always_comb begin
    is_lda = 1'b0;
    is_add = 1'b0;
    is_sub = 1'b0;
    is_out = 1'b0;
    // Priority chain keeps decode well defined even if parameters overlap.
    if      (opcode_q == OP_LDA) is_lda = 1'b1;
    else if (opcode_q == OP_ADD) is_add = 1'b1;
    else if (opcode_q == OP_SUB) is_sub = 1'b1;
    else if (opcode_q == OP_OUT) is_out = 1'b1;
  end

  always_comb begin
    pc_inc   = 1'b0;
    pc_en    = 1'b0;
    mar_load = 1'b0;
    ram_en   = 1'b0;
    ir_load  = 1'b0;
    ir_en    = 1'b0;
    a_load   = 1'b0;
    a_en     = 1'b0;
    sub      = 1'b0;
    alu_en   = 1'b0;
    b_load   = 1'b0;
    out_load = 1'b0;
    unique case (state_q)
      StT1: begin
        pc_en    = 1'b1;
        mar_load = 1'b1;
      end
      StT2: pc_inc = 1'b1;
      StT3: begin
        ram_en  = 1'b1;
        ir_load = 1'b1;
      end
      StT4: begin
        if (is_lda || is_add || is_sub) begin
          ir_en    = 1'b1;
          mar_load = 1'b1;
        end else if (is_out) begin
          a_en     = 1'b1;
          out_load = 1'b1;
        end
      end
      StT5: begin
        if (is_lda) begin
          ram_en = 1'b1;
          a_load = 1'b1;
        end else if (is_add || is_sub) begin
          ram_en = 1'b1;
          b_load = 1'b1;
        end
      end
      StT6: begin
        if (is_add || is_sub) begin
          alu_en = 1'b1;
          a_load = 1'b1;
          sub    = is_sub;
        end
      end
      default: ;
    endcase
  end

  assign t_state = state_q;
  assign halted  = (state_q == StHalt);

endmodule
